// File: rtl/decode_stage1_pkg.sv
// Shared opcode / register-field definitions for the decode stage.
// Holds field positions, opcode constants, the NOP word and the
// per-opcode operand-usage classification.
package decode_stage1_pkg;

    localparam int OPC_MSB  = 31;
    localparam int OPC_LSB  = 27;
    localparam int DST_MSB  = 26;
    localparam int DST_LSB  = 23;
    localparam int SRCA_MSB = 22;
    localparam int SRCA_LSB = 19;
    localparam int SRCB_MSB = 18;
    localparam int SRCB_LSB = 15;

    typedef enum logic [4:0] {
        OPCODE_NOP  = 5'h00,
        OPCODE_ADD  = 5'h01,
        OPCODE_SUB  = 5'h02,
        OPCODE_AND  = 5'h03,
        OPCODE_OR   = 5'h04,
        OPCODE_ADDI = 5'h05,
        OPCODE_LUI  = 5'h06,
        OPCODE_LD   = 5'h07,
        OPCODE_ST   = 5'h08,
        OPCODE_BEQ  = 5'h09
    } opcode_t;

    localparam logic [31:0] NOP_WORD = {OPCODE_NOP, 27'h0};

    typedef struct packed {
        logic reads_a;
        logic reads_b;
        logic writes_dst;
    } op_class_t;

    // Operand usage per opcode; NOP and unknown opcodes touch nothing.
    function automatic op_class_t classify(input logic [4:0] opc);
        op_class_t c;
        c = '0;
        case (opc)
            OPCODE_ADD, OPCODE_SUB,
            OPCODE_AND, OPCODE_OR:  c = '{reads_a: 1'b1, reads_b: 1'b1, writes_dst: 1'b1};
            OPCODE_ADDI, OPCODE_LD: c = '{reads_a: 1'b1, reads_b: 1'b0, writes_dst: 1'b1};
            OPCODE_LUI:             c = '{reads_a: 1'b0, reads_b: 1'b0, writes_dst: 1'b1};
            OPCODE_ST, OPCODE_BEQ:  c = '{reads_a: 1'b1, reads_b: 1'b1, writes_dst: 1'b0};
            default:                c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_stage1_scoreboard.sv
// stage1_scoreboard: tracks destination registers of the SB_DEPTH
// instructions issued downstream and flags read-after-write hazards.
// Entry 0 is the instruction most recently issued.
module stage1_scoreboard #(
    parameter int SB_DEPTH = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       shift_valid,
    input  logic [3:0] shift_dst,
    input  logic       flush,
    input  logic [3:0] src_a,
    input  logic       use_a,
    input  logic [3:0] src_b,
    input  logic       use_b,
    output logic       hazard
);

    logic [SB_DEPTH-1:0]      sb_valid;
    logic [SB_DEPTH-1:0][3:0] sb_dst;

    // Shift one place per clock; flush invalidates every entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sb_valid <= '0;
            sb_dst   <= '0;
        end else begin
            for (int i = SB_DEPTH-1; i >= 1; i--) begin
                sb_valid[i] <= flush ? 1'b0 : sb_valid[i-1];
                sb_dst[i]   <= sb_dst[i-1];
            end
            sb_valid[0] <= flush ? 1'b0 : shift_valid;
            sb_dst[0]   <= shift_dst;
        end
    end

    // Any valid in-flight writer matching a used source is a hazard.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (sb_valid[i] && ((use_a && sb_dst[i] == src_a) ||
                                (use_b && sb_dst[i] == src_b)))
                hazard = 1'b1;
        end
    end

endmodule

// File: rtl/decode_stage1.sv
// decode_stage1: first decode stage with a one-entry hold register and
// scoreboard-based RAW stall.
// Build option: STAGE1_SCOREBOARD_EN enables hazard detection; without it
// the stage is a plain one-cycle register (flush still inserts a NOP).
module decode_stage1
    import decode_stage1_pkg::*;
#(
    parameter int SB_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] inbound_instruction,
    input  logic        flush,
    output logic        block_fetch,
    output logic [3:0]  reg_read_a_index,
    output logic [3:0]  reg_read_b_index,
    output logic [31:0] outbound_instruction,
    output logic        hold_valid
);

    if (SB_DEPTH < 1 || SB_DEPTH > 4) begin : g_bad_depth
        $error("decode_stage1: SB_DEPTH must be 1..4");
    end

`ifdef STAGE1_SCOREBOARD_EN

    typedef enum logic {RUN, HOLD} state_t;

    state_t      state;
    logic [31:0] hold;
    logic [31:0] current;
    op_class_t   cls;
    logic        hazard;

    assign current          = (state == HOLD) ? hold : inbound_instruction;
    assign cls              = classify(current[OPC_MSB:OPC_LSB]);
    assign reg_read_a_index = current[SRCA_MSB:SRCA_LSB];
    assign reg_read_b_index = current[SRCB_MSB:SRCB_LSB];
    assign block_fetch      = hazard & ~flush;
    assign hold_valid       = (state == HOLD);

    // A stalled slot issues a bubble, so nothing is recorded for it.
    stage1_scoreboard #(.SB_DEPTH(SB_DEPTH)) u_scoreboard (
        .clock       (clock),
        .reset       (reset),
        .shift_valid (cls.writes_dst & ~hazard),
        .shift_dst   (current[DST_MSB:DST_LSB]),
        .flush       (flush),
        .src_a       (current[SRCA_MSB:SRCA_LSB]),
        .use_a       (cls.reads_a),
        .src_b       (current[SRCB_MSB:SRCB_LSB]),
        .use_b       (cls.reads_b),
        .hazard      (hazard)
    );

    // RUN/HOLD control: flush wins, hazard parks the instruction, else issue.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state                <= RUN;
            hold                 <= NOP_WORD;
            outbound_instruction <= NOP_WORD;
        end else if (flush) begin
            state                <= RUN;
            hold                 <= NOP_WORD;
            outbound_instruction <= NOP_WORD;
        end else if (hazard) begin
            if (state == RUN) begin
                hold  <= inbound_instruction;
                state <= HOLD;
            end
            outbound_instruction <= NOP_WORD;
        end else begin
            outbound_instruction <= current;
            state                <= RUN;
        end
    end

`else

    assign reg_read_a_index = inbound_instruction[SRCA_MSB:SRCA_LSB];
    assign reg_read_b_index = inbound_instruction[SRCB_MSB:SRCB_LSB];
    assign block_fetch      = 1'b0;
    assign hold_valid       = 1'b0;

    // Plain pipeline register; flush replaces the instruction with a NOP.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)      outbound_instruction <= NOP_WORD;
        else if (flush) outbound_instruction <= NOP_WORD;
        else            outbound_instruction <= inbound_instruction;
    end

`endif

endmodule

// File: tb/tb_decode_stage1.sv
// Directed bench for decode_stage1 (SB_DEPTH = 2 main instance, plus an
// SB_DEPTH = 1 instance sharing the same inputs for the depth comparison).
module tb_decode_stage1;

`ifdef STAGE1_SCOREBOARD_EN
    localparam bit SCB = 1'b1;
`else
    localparam bit SCB = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic [31:0] inbound_instruction;
    logic        flush;
    logic        block_fetch, block_fetch1;
    logic [3:0]  rra, rrb, rra1, rrb1;
    logic [31:0] outbound, outbound1;
    logic        hold_valid, hold_valid1;

    int checks   = 0;
    int failures = 0;

    decode_stage1 #(.SB_DEPTH(2)) dut (
        .clock(clock), .reset(reset), .inbound_instruction(inbound_instruction),
        .flush(flush), .block_fetch(block_fetch), .reg_read_a_index(rra),
        .reg_read_b_index(rrb), .outbound_instruction(outbound), .hold_valid(hold_valid)
    );

    decode_stage1 #(.SB_DEPTH(1)) dut1 (
        .clock(clock), .reset(reset), .inbound_instruction(inbound_instruction),
        .flush(flush), .block_fetch(block_fetch1), .reg_read_a_index(rra1),
        .reg_read_b_index(rrb1), .outbound_instruction(outbound1), .hold_valid(hold_valid1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam logic [31:0] NOP = 32'h0000_0000;

    function automatic logic [31:0] add(input logic [3:0] d, input logic [3:0] a, input logic [3:0] b);
        return {5'h01, d, a, b, 15'h0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        inbound_instruction = NOP;
        repeat (2) @(posedge clock);
        #1;
        check("rst_out", outbound, NOP);
        check("rst_hv", {31'b0, hold_valid}, 0);
        check("rst_bf", {31'b0, block_fetch}, 0);
        reset = 1'b0;

        // Independent back-to-back ADDs
        inbound_instruction = add(3, 1, 2); #1;
        check("ind_bf0", {31'b0, block_fetch}, 0);
        check("ind_rra", {28'b0, rra}, 1);
        check("ind_rrb", {28'b0, rrb}, 2);
        tick();
        check("ind_out0", outbound, add(3, 1, 2));
        inbound_instruction = add(5, 4, 6); #1;
        check("ind_bf1", {31'b0, block_fetch}, 0);
        tick();
        check("ind_out1", outbound, add(5, 4, 6));
        inbound_instruction = NOP;
        tick();
        check("ind_out2", outbound, NOP);
        tick();

        // Dependent pair, two-cycle stall
        inbound_instruction = add(3, 1, 2); #1;
        check("dep_bf0", {31'b0, block_fetch}, 0);
        tick();
        check("dep_out0", outbound, add(3, 1, 2));
        inbound_instruction = add(4, 3, 0); #1;
        check("dep_bf1", {31'b0, block_fetch}, {31'b0, SCB});
        tick();
        check("dep_out1", outbound, SCB ? NOP : add(4, 3, 0));
        check("dep_hv1", {31'b0, hold_valid}, {31'b0, SCB});
        inbound_instruction = NOP; #1;
        check("dep_bf2", {31'b0, block_fetch}, {31'b0, SCB});
        check("dep_rra2", {28'b0, rra}, SCB ? 32'd3 : 32'd0);
        tick();
        check("dep_out2", outbound, NOP);
        check("dep_hv2", {31'b0, hold_valid}, {31'b0, SCB});
        #1;
        check("dep_bf3", {31'b0, block_fetch}, 0);
        tick();
        check("dep_out3", outbound, SCB ? add(4, 3, 0) : NOP);
        check("dep_hv3", {31'b0, hold_valid}, 0);
        tick(); tick();

        // Flush during stall
        inbound_instruction = add(3, 1, 2);
        tick();
        inbound_instruction = add(4, 3, 0);
        tick();
        check("fl_hv", {31'b0, hold_valid}, {31'b0, SCB});
        inbound_instruction = NOP; flush = 1'b1; #1;
        check("fl_bf", {31'b0, block_fetch}, 0);
        tick();
        check("fl_out", outbound, NOP);
        check("fl_hv2", {31'b0, hold_valid}, 0);
        flush = 1'b0;
        inbound_instruction = add(8, 3, 3); #1;
        check("fl_next_bf", {31'b0, block_fetch}, 0);
        tick();
        check("fl_next_out", outbound, add(8, 3, 3));
        inbound_instruction = add(5, 1, 1); flush = 1'b1;
        tick();
        check("fl_kill_out", outbound, NOP);
        flush = 1'b0; inbound_instruction = NOP;
        tick(); tick();

        // Reset mid-stall
        inbound_instruction = add(3, 1, 2);
        tick();
        inbound_instruction = add(4, 3, 0);
        tick();
        inbound_instruction = NOP; #1;
        check("rs_bf_pre", {31'b0, block_fetch}, {31'b0, SCB});
        reset = 1'b1; #1;
        check("rs_out", outbound, NOP);
        check("rs_hv", {31'b0, hold_valid}, 0);
        check("rs_bf", {31'b0, block_fetch}, 0);
        reset = 1'b0;
        inbound_instruction = add(4, 3, 0); #1;
        check("rs_next_bf", {31'b0, block_fetch}, 0);
        tick();
        check("rs_next_out", outbound, add(4, 3, 0));
        inbound_instruction = NOP;
        tick(); tick();

        // Hazard two slots away: depth 2 stalls once, depth 1 not at all
        reset = 1'b1; #1; reset = 1'b0;
        inbound_instruction = add(3, 1, 2);
        tick();
        inbound_instruction = NOP;
        tick();
        inbound_instruction = add(7, 3, 3); #1;
        check("d2_bf", {31'b0, block_fetch}, {31'b0, SCB});
        check("d1_bf", {31'b0, block_fetch1}, 0);
        tick();
        check("d2_out0", outbound, SCB ? NOP : add(7, 3, 3));
        check("d1_out0", outbound1, add(7, 3, 3));
        inbound_instruction = NOP; #1;
        check("d2_bf1", {31'b0, block_fetch}, 0);
        tick();
        check("d2_out1", outbound, SCB ? add(7, 3, 3) : NOP);
        check("d1_out1", outbound1, NOP);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
